// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - button synchroniser, debouncer, edge detector and move/lockout FSM
// Produces one-cycle dir codes and game_rst pulses for gameController.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LOCKOUT_CYCLES  = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_reset,
  output logic [2:0] dir,
  output logic       game_rst,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0] DIR_IDLE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_LOCK,
    S_WAIT_REL
  } state_t;

  // Bit order: 0=up 1=down 2=left 3=right 4=reset, so bit index equals dir code.
  logic [4:0]    w_raw;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    r_stable;
  logic [4:0]    r_stable_q;
  logic [4:0]    r_press;
  logic [CW-1:0] r_cnt [0:4];

  state_t        r_state;
  state_t        w_next;
  logic [LW-1:0] r_lock_cnt;
  logic [LW-1:0] w_lock_next;
  logic [2:0]    w_dir_next;
  logic          w_grst_next;

  assign w_raw = {btn_reset, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
      r_press    <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      r_press    <= r_stable & ~r_stable_q;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lock_cnt <= '0;
      dir        <= DIR_IDLE;
      game_rst   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_lock_cnt <= w_lock_next;
      dir        <= w_dir_next;
      game_rst   <= w_grst_next;
      busy       <= (w_next != S_IDLE);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_lock_next = r_lock_cnt;
    w_dir_next  = DIR_IDLE;
    w_grst_next = 1'b0;
    // A reset press overrides everything, including a coincident direction press.
    if (r_press[4]) begin
      w_grst_next = 1'b1;
      w_next      = S_WAIT_REL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|r_press[3:0]) begin
            w_next = S_FIRE;
            if (r_press[0])      w_dir_next = 3'd0;
            else if (r_press[1]) w_dir_next = 3'd1;
            else if (r_press[2]) w_dir_next = 3'd2;
            else                 w_dir_next = 3'd3;
          end
        end
        S_FIRE: begin
          w_next      = S_LOCK;
          w_lock_next = LW'(LOCKOUT_CYCLES - 1);
        end
        S_LOCK: begin
          if (r_lock_cnt == '0) w_next = S_WAIT_REL;
          else                  w_lock_next = r_lock_cnt - LW'(1);
        end
        S_WAIT_REL: begin
          if (r_stable[3:0] == 4'b0000) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
// Runs with DEBOUNCE_CYCLES=4 and LOCKOUT_CYCLES=8; outputs are sampled on the falling edge.
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_reset;
  logic [2:0] dir;
  logic       game_rst;
  logic       busy;

  int n_checks;
  int n_fail;
  int cyc;
  int n_code [4];
  int n_grst;
  int n_busy;
  int n_both;
  int pulses[$];

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_reset(btn_reset),
    .dir      (dir),
    .game_rst (game_rst),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) n_code[i] = 0;
    n_grst = 0;
    n_busy = 0;
    n_both = 0;
    pulses.delete();
  endtask

  // Each tick crosses one rising edge and returns at the following falling edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (dir < 3'd4) begin
        n_code[dir[1:0]]++;
        pulses.push_back(cyc);
      end
      if (game_rst) n_grst++;
      if (busy) n_busy++;
      if (game_rst && dir != 3'd4) n_both++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_reset = 1'b0;
    clear_mon();
    @(negedge clk);
    @(negedge clk);
    check("rst_dir", int'(dir), 4);
    check("rst_grst", int'(game_rst), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    run(3);

    // 1: held left -> dir==2 exactly in the cycle after edge 7
    clear_mon();
    btn_left = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      run(1);
      check($sformatf("t1_dir_e%0d", k), int'(dir), (k == 7) ? 2 : 4);
      check($sformatf("t1_busy_e%0d", k), int'(busy), (k >= 7) ? 1 : 0);
    end
    btn_left = 1'b0;
    run(30);
    check("t1_busy_released", int'(busy), 0);

    // 2: 3-cycle glitch on up
    clear_mon();
    btn_up = 1'b1;
    run(3);
    btn_up = 1'b0;
    run(20);
    check("t2_up_pulses", n_code[0], 0);
    check("t2_busy_cycles", n_busy, 0);

    // 3: right+down together -> down wins
    clear_mon();
    btn_right = 1'b1;
    btn_down  = 1'b1;
    run(20);
    check("t3_down_pulses", n_code[1], 1);
    check("t3_right_pulses", n_code[3], 0);
    check("t3_busy_held", int'(busy), 1);
    btn_right = 1'b0;
    btn_down  = 1'b0;
    run(30);
    check("t3_busy_released", int'(busy), 0);

    // 4: long hold gives one pulse, re-press gives a second
    clear_mon();
    btn_up = 1'b1;
    run(100);
    check("t4_hold_pulses", n_code[0], 1);
    btn_up = 1'b0;
    run(20);
    btn_up = 1'b1;
    run(20);
    btn_up = 1'b0;
    run(30);
    check("t4_total_pulses", n_code[0], 2);
    if (pulses.size() >= 2)
      check("t4_gap_ok", int'((pulses[1] - pulses[0]) >= 9), 1);
    else
      check("t4_pulse_count", pulses.size(), 2);

    // 5a: down pressed during lockout is dropped
    clear_mon();
    btn_left = 1'b1;
    run(9);
    btn_down = 1'b1;
    run(20);
    check("t5_left_pulses", n_code[2], 1);
    check("t5_down_pulses", n_code[1], 0);
    btn_left = 1'b0;
    btn_down = 1'b0;
    run(30);
    check("t5_down_after", n_code[1], 0);

    // 5b: reset pressed during lockout
    clear_mon();
    btn_right = 1'b1;
    run(8);
    btn_reset = 1'b1;
    run(20);
    check("t5_right_pulses", n_code[3], 1);
    check("t5_grst_pulses", n_grst, 1);
    check("t5_grst_with_dir", n_both, 0);
    btn_right = 1'b0;
    btn_reset = 1'b0;
    run(30);
    check("t5_busy_released", int'(busy), 0);

    // 6a: reset and left debounce together -> reset wins
    clear_mon();
    btn_reset = 1'b1;
    btn_left  = 1'b1;
    run(20);
    check("t6_grst_pulses", n_grst, 1);
    check("t6_left_pulses", n_code[2], 0);
    check("t6_grst_with_dir", n_both, 0);
    btn_reset = 1'b0;
    btn_left  = 1'b0;
    run(30);
    check("t6_busy_released", int'(busy), 0);

    // 6b: rst while a dir pulse is out clears outputs at once
    clear_mon();
    btn_up = 1'b1;
    run(8);
    check("t6_pulse_before_rst", int'(dir), 0);
    rst = 1'b1;
    #1;
    check("t6_rst_dir", int'(dir), 4);
    check("t6_rst_grst", int'(game_rst), 0);
    check("t6_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    run(15);
    check("t6_held_through_rst", n_code[0], 1);
    check("t6_no_grst", n_grst, 0);
    btn_up = 1'b0;
    run(30);
    check("t6_final_busy", int'(busy), 0);
    check("t6_final_dir", int'(dir), 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
